ddr2_app_arbiter: RTL and testbench

- Two-port round-robin arbiter that shares the DDR2 controller application interface (address FIFO, write-data FIFO, read-data return) between two independent requesters.
- Serialises read and write commands and streams write bursts, honouring the controller's almost-full flags.
- Tracks outstanding reads in a tag FIFO so returned read beats are steered to the requester that issued them.
- Sits between user logic and the controller's app_af_*/app_wdf_* inputs.

---
 rtl/ddr2_app_arbiter.sv | 206 ++++++++++++++++++++
 tb/tb_ddr2_app_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr2_app_arbiter.sv
// Two-port round-robin arbiter in front of the DDR2 controller application interface.
// Serialises read/write commands, streams write bursts and steers read beats back via a tag FIFO.
module ddr2_app_arbiter #(
   parameter int DQ_WIDTH  = 72,
   parameter int DM_WIDTH  = 9,
   parameter int TAG_DEPTH = 16
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    init_done,
   input  logic                    af_almost_full,
   input  logic                    wdf_almost_full,
   input  logic [2:0]              burst_length_div2,
   input  logic                    read_data_valid,
   input  logic [2*DQ_WIDTH-1:0]   read_data_fifo_out,
   input  logic                    req0_valid,
   input  logic                    req0_rd,
   input  logic [31:0]             req0_addr,
   output logic                    req0_ready,
   input  logic                    req1_valid,
   input  logic                    req1_rd,
   input  logic [31:0]             req1_addr,
   output logic                    req1_ready,
   input  logic [2*DQ_WIDTH-1:0]   wr0_data,
   input  logic [2*DM_WIDTH-1:0]   wr0_mask,
   output logic                    wr0_pop,
   input  logic [2*DQ_WIDTH-1:0]   wr1_data,
   input  logic [2*DM_WIDTH-1:0]   wr1_mask,
   output logic                    wr1_pop,
   output logic                    rd0_valid,
   output logic                    rd1_valid,
   output logic [2*DQ_WIDTH-1:0]   rd_data,
   output logic [35:0]             app_af_addr,
   output logic                    app_af_wren,
   output logic [2*DQ_WIDTH-1:0]   app_wdf_data,
   output logic [2*DM_WIDTH-1:0]   app_mask_data,
   output logic                    app_wdf_wren,
   output logic                    rd_unexpected
);

   localparam int DW  = 2*DQ_WIDTH;
   localparam int MW  = 2*DM_WIDTH;
   localparam int TAW = $clog2(TAG_DEPTH);

   typedef enum logic [1:0] {IDLE = 2'd0, RCMD = 2'd1, WDATA = 2'd2} state_t;

   typedef struct packed {
      logic [2:0] bl;
      logic       port;
   } tag_t;

   function automatic logic [2:0] clamp_bl(input logic [2:0] b);
      if (b == 3'd0 || b > 3'd4) return 3'd4;
      return b;
   endfunction

   state_t           state_q, state_d;
   logic             port_q, port_d;
   logic [31:0]      addr_q, addr_d;
   logic [2:0]       bl_q, bl_d;
   logic [2:0]       beat_q, beat_d;
   logic             wdf_af_q;

   tag_t             tag_mem_q [TAG_DEPTH];
   logic [TAW:0]     tag_wr_q, tag_rd_q;
   logic             tag_empty, tag_full, tag_push, tag_pop;
   tag_t             tag_head;

   logic [2:0]       rd_cnt_q, rd_cnt_d, rd_rem;
   logic             rd0_valid_q, rd0_valid_d, rd1_valid_q, rd1_valid_d;
   logic             unexp_q, unexp_d;
   logic [DW-1:0]    rd_data_q;

   logic             elig0, elig1, gnt_any, gnt_port, sel_rd;
   logic [31:0]      sel_addr;

   assign tag_empty = (tag_wr_q == tag_rd_q);
   assign tag_full  = (tag_wr_q[TAW] != tag_rd_q[TAW]) &&
                      (tag_wr_q[TAW-1:0] == tag_rd_q[TAW-1:0]);
   assign tag_head  = tag_mem_q[tag_rd_q[TAW-1:0]];

   assign elig0 = req0_valid & init_done & ~af_almost_full & (req0_rd ? ~tag_full : ~wdf_af_q);
   assign elig1 = req1_valid & init_done & ~af_almost_full & (req1_rd ? ~tag_full : ~wdf_af_q);
   // With both eligible the port not granted last wins; reset keeps ready low while asserted.
   assign gnt_port = (elig0 & elig1) ? ~port_q : elig1;
   assign gnt_any  = (elig0 | elig1) & reset;
   assign sel_rd   = gnt_port ? req1_rd   : req0_rd;
   assign sel_addr = gnt_port ? req1_addr : req0_addr;

   always_comb begin
      state_d      = state_q;
      port_d       = port_q;
      addr_d       = addr_q;
      bl_d         = bl_q;
      beat_d       = beat_q;
      req0_ready   = 1'b0;
      req1_ready   = 1'b0;
      app_af_wren  = 1'b0;
      app_wdf_wren = 1'b0;
      wr0_pop      = 1'b0;
      wr1_pop      = 1'b0;
      tag_push     = 1'b0;
      case (state_q)
         IDLE: begin
            if (gnt_any) begin
               req0_ready = ~gnt_port;
               req1_ready = gnt_port;
               port_d     = gnt_port;
               addr_d     = sel_addr;
               bl_d       = clamp_bl(burst_length_div2);
               beat_d     = clamp_bl(burst_length_div2);
               state_d    = sel_rd ? RCMD : WDATA;
            end
         end
         RCMD: begin
            app_af_wren = 1'b1;
            tag_push    = 1'b1;
            state_d     = IDLE;
         end
         WDATA: begin
            if (!wdf_af_q) begin
               app_wdf_wren = 1'b1;
               wr0_pop      = ~port_q;
               wr1_pop      = port_q;
               beat_d       = beat_q - 3'd1;
               // Address goes in with the last beat; af headroom covers a late almost-full.
               if (beat_q <= 3'd1) begin
                  app_af_wren = 1'b1;
                  state_d     = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign app_af_addr   = app_af_wren ? {1'b0, (state_q == RCMD) ? 3'b101 : 3'b100, addr_q} : '0;
   assign app_wdf_data  = app_wdf_wren ? (port_q ? wr1_data : wr0_data) : '0;
   assign app_mask_data = app_wdf_wren ? (port_q ? wr1_mask : wr0_mask) : '0;

   always_comb begin
      rd_cnt_d    = rd_cnt_q;
      rd_rem      = 3'd0;
      tag_pop     = 1'b0;
      rd0_valid_d = 1'b0;
      rd1_valid_d = 1'b0;
      unexp_d     = unexp_q;
      if (read_data_valid) begin
         if (tag_empty) begin
            unexp_d = 1'b1;
         end else begin
            rd_rem      = (rd_cnt_q == 3'd0) ? tag_head.bl : rd_cnt_q;
            rd0_valid_d = ~tag_head.port;
            rd1_valid_d = tag_head.port;
            if (rd_rem <= 3'd1) begin
               tag_pop  = 1'b1;
               rd_cnt_d = 3'd0;
            end else begin
               rd_cnt_d = rd_rem - 3'd1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         port_q      <= 1'b1;
         addr_q      <= '0;
         bl_q        <= '0;
         beat_q      <= '0;
         wdf_af_q    <= 1'b0;
         tag_wr_q    <= '0;
         tag_rd_q    <= '0;
         rd_cnt_q    <= '0;
         rd0_valid_q <= 1'b0;
         rd1_valid_q <= 1'b0;
         unexp_q     <= 1'b0;
         rd_data_q   <= '0;
      end else begin
         state_q     <= state_d;
         port_q      <= port_d;
         addr_q      <= addr_d;
         bl_q        <= bl_d;
         beat_q      <= beat_d;
         wdf_af_q    <= wdf_almost_full;
         if (tag_push) tag_wr_q <= tag_wr_q + (TAW+1)'(1);
         if (tag_pop)  tag_rd_q <= tag_rd_q + (TAW+1)'(1);
         rd_cnt_q    <= rd_cnt_d;
         rd0_valid_q <= rd0_valid_d;
         rd1_valid_q <= rd1_valid_d;
         unexp_q     <= unexp_d;
         rd_data_q   <= read_data_fifo_out;
      end
   end

   always_ff @(posedge clk) begin
      if (tag_push) tag_mem_q[tag_wr_q[TAW-1:0]] <= {bl_q, port_q};
   end

   assign rd0_valid     = rd0_valid_q;
   assign rd1_valid     = rd1_valid_q;
   assign rd_data       = rd_data_q;
   assign rd_unexpected = unexp_q;

endmodule

// File: tb/tb_ddr2_app_arbiter.sv
// Scoreboard bench for ddr2_app_arbiter: stimulus pushes expected grants, address words,
// write beats and read returns; a negedge monitor pops and compares them.
module tb_ddr2_app_arbiter;
   localparam int DQ = 72;
   localparam int DM = 9;
   localparam int DW = 2*DQ;
   localparam int MW = 2*DM;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic init_done = 1'b0, af_almost_full = 1'b0, wdf_almost_full = 1'b0;
   logic [2:0] burst_length_div2 = 3'd2;
   logic read_data_valid = 1'b0;
   logic [DW-1:0] read_data_fifo_out = '0;
   logic req0_valid = 1'b0, req0_rd = 1'b0, req1_valid = 1'b0, req1_rd = 1'b0;
   logic [31:0] req0_addr = '0, req1_addr = '0;
   logic req0_ready, req1_ready, wr0_pop, wr1_pop, rd0_valid, rd1_valid;
   logic [DW-1:0] wr0_data, wr1_data, rd_data, app_wdf_data;
   logic [MW-1:0] wr0_mask, wr1_mask, app_mask_data;
   logic [35:0] app_af_addr;
   logic app_af_wren, app_wdf_wren, rd_unexpected;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct packed { logic p; logic [DW-1:0] d; logic [MW-1:0] m; } wexp_t;
   typedef struct packed { logic p; logic [DW-1:0] d; } rexp_t;
   int          gq[$];
   logic [35:0] aq[$];
   wexp_t       wq[$];
   rexp_t       rq[$];
   int          wn[2] = '{0, 0};
   int          rseq = 0;
   logic [31:0] pidx0 = 0, pidx1 = 0;

   ddr2_app_arbiter #(.DQ_WIDTH(DQ), .DM_WIDTH(DM), .TAG_DEPTH(16)) dut (
      .clk(clk), .reset(reset), .init_done(init_done),
      .af_almost_full(af_almost_full), .wdf_almost_full(wdf_almost_full),
      .burst_length_div2(burst_length_div2), .read_data_valid(read_data_valid),
      .read_data_fifo_out(read_data_fifo_out),
      .req0_valid(req0_valid), .req0_rd(req0_rd), .req0_addr(req0_addr), .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_rd(req1_rd), .req1_addr(req1_addr), .req1_ready(req1_ready),
      .wr0_data(wr0_data), .wr0_mask(wr0_mask), .wr0_pop(wr0_pop),
      .wr1_data(wr1_data), .wr1_mask(wr1_mask), .wr1_pop(wr1_pop),
      .rd0_valid(rd0_valid), .rd1_valid(rd1_valid), .rd_data(rd_data),
      .app_af_addr(app_af_addr), .app_af_wren(app_af_wren),
      .app_wdf_data(app_wdf_data), .app_mask_data(app_mask_data),
      .app_wdf_wren(app_wdf_wren), .rd_unexpected(rd_unexpected)
   );

   always #5 clk = ~clk;

   function automatic logic [DW-1:0] wbeat(input int p, input int idx);
      logic [DW-1:0] v;
      v = '0;
      v[DW-1 -: 4] = 4'(p + 1);
      v[31:0] = 32'(idx) + 32'h100;
      return v;
   endfunction

   function automatic logic [MW-1:0] wmask(input int p, input int idx);
      return 18'(idx) ^ ((p != 0) ? 18'h2aaaa : 18'h15555);
   endfunction

   function automatic logic [DW-1:0] rpat(input int s);
      logic [DW-1:0] v;
      v = '0;
      v[DW-1 -: 16] = 16'(s) + 16'h8000;
      v[DW/2 +: 16] = 16'hA5A5 ^ 16'(s);
      v[31:0] = 32'(s) ^ 32'h1234_5678;
      return v;
   endfunction

   // FIFO models of the requesters' first-word-fall-through write queues
   assign wr0_data = wbeat(0, int'(pidx0));
   assign wr0_mask = wmask(0, int'(pidx0));
   assign wr1_data = wbeat(1, int'(pidx1));
   assign wr1_mask = wmask(1, int'(pidx1));
   always @(posedge clk) begin
      if (wr0_pop) pidx0 <= pidx0 + 1;
      if (wr1_pop) pidx1 <= pidx1 + 1;
   end

   task automatic chk(input string nm, input logic [199:0] got, input logic [199:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", nm, got, exp);
      end
   endtask

   task automatic push_exp(input int p, input bit rd, input logic [31:0] a, input logic [2:0] bl);
      int blc;
      gq.push_back(p);
      aq.push_back({1'b0, rd ? 3'b101 : 3'b100, a});
      if (!rd) begin
         blc = (bl == 3'd0 || bl > 3'd4) ? 4 : int'(bl);
         for (int b = 0; b < blc; b++) begin
            wq.push_back(wexp_t'{p[0], wbeat(p, wn[p]), wmask(p, wn[p])});
            wn[p]++;
         end
      end
   endtask

   task automatic drive(input int p, input bit rd, input logic [31:0] a, input logic [2:0] bl);
      if (p == 0) begin req0_valid = 1'b1; req0_rd = rd; req0_addr = a; end
      else        begin req1_valid = 1'b1; req1_rd = rd; req1_addr = a; end
      burst_length_div2 = bl;
   endtask

   task automatic wait_ready(input int p);
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if ((p == 0) ? req0_ready : req1_ready) return;
      end
      n_checks++;
      n_errors++;
      $display("FAIL ready_timeout: port %0d got no ready within 100 cycles", p);
   endtask

   task automatic ret_burst(input int p, input int bl);
      for (int b = 0; b < bl; b++) begin
         @(posedge clk); #1;
         read_data_valid = 1'b1;
         read_data_fifo_out = rpat(rseq);
         rq.push_back(rexp_t'{p[0], rpat(rseq)});
         rseq++;
      end
   endtask

   // Monitor: every DUT strobe must match the head of its expectation queue
   int    m_g;
   logic [35:0] m_a;
   wexp_t m_w;
   rexp_t m_r;
   always @(negedge clk) begin
      if (req0_ready || req1_ready) begin
         if (gq.size() == 0) begin
            n_checks++; n_errors++;
            $display("FAIL grant_unexpected: got ready %b%b expected none", req1_ready, req0_ready);
         end else begin
            m_g = gq.pop_front();
            chk("grant_port", {req1_ready, req0_ready}, (m_g != 0) ? 2'b10 : 2'b01);
         end
      end
      if (app_af_wren) begin
         if (aq.size() == 0) begin
            n_checks++; n_errors++;
            $display("FAIL af_unexpected: got app_af_addr %h expected no strobe", app_af_addr);
         end else begin
            m_a = aq.pop_front();
            chk("af_addr", app_af_addr, m_a);
         end
      end
      if (app_wdf_wren) begin
         if (wq.size() == 0) begin
            n_checks++; n_errors++;
            $display("FAIL wdf_unexpected: got app_wdf_data %h expected no strobe", app_wdf_data);
         end else begin
            m_w = wq.pop_front();
            chk("wdf_data", {app_wdf_data, app_mask_data}, {m_w.d, m_w.m});
            chk("wdf_pop", {wr1_pop, wr0_pop}, m_w.p ? 2'b10 : 2'b01);
         end
      end
      if (rd0_valid || rd1_valid) begin
         if (rq.size() == 0) begin
            n_checks++; n_errors++;
            $display("FAIL rd_unexpected_beat: got rd valid %b%b expected none", rd1_valid, rd0_valid);
         end else begin
            m_r = rq.pop_front();
            chk("rd_port", {rd1_valid, rd0_valid}, m_r.p ? 2'b10 : 2'b01);
            chk("rd_data", rd_data, m_r.d);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   logic seen0;
   initial begin
      // Reset with active-looking inputs: every output must stay low
      #2 reset = 1'b0;
      init_done = 1'b1; req0_valid = 1'b1; read_data_valid = 1'b1; read_data_fifo_out = '1;
      repeat (3) @(negedge clk);
      chk("reset_ctrl", {app_af_wren, app_wdf_wren, wr0_pop, wr1_pop, req0_ready, req1_ready,
                         rd0_valid, rd1_valid, rd_unexpected}, '0);
      chk("reset_af_addr", app_af_addr, '0);
      chk("reset_wdf", {app_wdf_data, app_mask_data}, '0);
      chk("reset_rd_data", rd_data, '0);
      req0_valid = 1'b0; read_data_valid = 1'b0; read_data_fifo_out = '0;
      @(posedge clk); #1 reset = 1'b1;
      repeat (2) @(posedge clk); #1;

      // Single BL4 write on port 0
      push_exp(0, 1'b0, 32'h0000_0040, 3'd2);
      drive(0, 1'b0, 32'h0000_0040, 3'd2);
      wait_ready(0);
      chk("wr_T_wdf", app_wdf_wren, 1'b0);
      @(posedge clk); #1 req0_valid = 1'b0;
      @(negedge clk);
      chk("wr_T1_wdf", app_wdf_wren, 1'b1);
      chk("wr_T1_af", app_af_wren, 1'b0);
      @(negedge clk);
      chk("wr_T2_wdf", app_wdf_wren, 1'b1);
      chk("wr_T2_af", app_af_wren, 1'b1);
      chk("wr_T2_cmd", app_af_addr[34:32], 3'b100);
      @(negedge clk);
      chk("wr_T3_idle", {app_wdf_wren, app_af_wren}, 2'b00);

      // Port 1 write, burst length 6 clamped to 4, with a 3-cycle wdf almost-full stall
      @(posedge clk); #1;
      push_exp(1, 1'b0, 32'h0000_2000, 3'd6);
      drive(1, 1'b0, 32'h0000_2000, 3'd6);
      wait_ready(1);
      for (int k = 1; k <= 7; k++) begin
         @(posedge clk); #1;
         if (k == 1) req1_valid = 1'b0;
         if (k == 2) wdf_almost_full = 1'b1;
         if (k == 5) wdf_almost_full = 1'b0;
         @(negedge clk);
         chk($sformatf("stall_wdf_c%0d", k), app_wdf_wren, (k >= 3 && k <= 5) ? 1'b0 : 1'b1);
         chk($sformatf("stall_af_c%0d", k), app_af_wren, (k == 7));
      end

      // Both ports issuing BL8 reads back to back: grants alternate 0,1,0,1
      repeat (2) @(posedge clk); #1;
      push_exp(0, 1'b1, 32'h0000_A000, 3'd4);
      push_exp(1, 1'b1, 32'h0000_B000, 3'd4);
      push_exp(0, 1'b1, 32'h0000_A100, 3'd4);
      push_exp(1, 1'b1, 32'h0000_B100, 3'd4);
      fork
         begin
            drive(0, 1'b1, 32'h0000_A000, 3'd4); wait_ready(0);
            @(posedge clk); #1 drive(0, 1'b1, 32'h0000_A100, 3'd4); wait_ready(0);
            @(posedge clk); #1 req0_valid = 1'b0;
         end
         begin
            drive(1, 1'b1, 32'h0000_B000, 3'd4); wait_ready(1);
            @(posedge clk); #1 drive(1, 1'b1, 32'h0000_B100, 3'd4); wait_ready(1);
            @(posedge clk); #1 req1_valid = 1'b0;
         end
      join
      repeat (3) @(posedge clk);
      for (int b = 0; b < 4; b++) ret_burst(b % 2, 4);
      @(posedge clk); #1 read_data_valid = 1'b0;
      repeat (4) @(posedge clk); #1;

      // Fill the tag FIFO with 16 reads; a 17th read waits while a write still gets in
      for (int i = 0; i < 16; i++) begin
         push_exp(0, 1'b1, 32'h0000_1000 + 32'(i * 8), 3'd2);
         drive(0, 1'b1, 32'h0000_1000 + 32'(i * 8), 3'd2);
         wait_ready(0);
         @(posedge clk); #1 req0_valid = 1'b0;
      end
      push_exp(1, 1'b0, 32'h0000_3000, 3'd0);
      drive(0, 1'b1, 32'h0000_1800, 3'd2);
      drive(1, 1'b0, 32'h0000_3000, 3'd0);
      wait_ready(1);
      @(posedge clk); #1 req1_valid = 1'b0;
      seen0 = 1'b0;
      repeat (12) begin
         @(negedge clk);
         if (req0_ready) seen0 = 1'b1;
      end
      chk("full_read_blocked", seen0, 1'b0);
      @(posedge clk); #1 req0_valid = 1'b0;
      for (int i = 0; i < 16; i++) ret_burst(0, 2);
      @(posedge clk); #1 read_data_valid = 1'b0;
      repeat (3) @(posedge clk);

      // Read beat with nothing outstanding
      @(negedge clk);
      chk("unexp_before", rd_unexpected, 1'b0);
      @(posedge clk); #1 read_data_valid = 1'b1; read_data_fifo_out = rpat(999);
      @(posedge clk); #1 read_data_valid = 1'b0;
      @(negedge clk);
      chk("unexp_set", rd_unexpected, 1'b1);
      repeat (3) @(negedge clk);
      chk("unexp_sticky", rd_unexpected, 1'b1);

      // Reset in the middle of a write burst: only the first beat may appear
      @(posedge clk); #1;
      gq.push_back(0);
      wq.push_back(wexp_t'{1'b0, wbeat(0, wn[0]), wmask(0, wn[0])});
      drive(0, 1'b0, 32'h0000_4000, 3'd4);
      wait_ready(0);
      @(posedge clk); #1 req0_valid = 1'b0;
      @(negedge clk);
      #2 reset = 1'b0;
      #1;
      chk("midrst_ctrl", {app_af_wren, app_wdf_wren, wr0_pop, wr1_pop, req0_ready, req1_ready,
                          rd0_valid, rd1_valid, rd_unexpected}, '0);
      chk("midrst_af_addr", app_af_addr, '0);
      chk("midrst_wdf", {app_wdf_data, app_mask_data}, '0);
      chk("midrst_rd_data", rd_data, '0);
      repeat (2) @(posedge clk); #1 reset = 1'b1;
      repeat (10) @(posedge clk);
      @(negedge clk);
      chk("after_rst_idle", {app_af_wren, app_wdf_wren}, 2'b00);

      chk("gq_drained", gq.size(), 0);
      chk("aq_drained", aq.size(), 0);
      chk("wq_drained", wq.size(), 0);
      chk("rq_drained", rq.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
